// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// vga_pkg
// Shared 640x480 @ 60 Hz timing constants and coordinate width.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

    localparam int VGA_CLK_DIV   = 4;
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam logic SYNC_ACTIVE = 1'b0;
    localparam int   COORD_W     = 10;

    function automatic logic in_window(input logic [COORD_W-1:0] val,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/contador_mod_n.sv
//------------------------------------------------------------------------------
// contador_mod_n
// Modulo-N counter with enable, synchronous reset, wrap flag and next value.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module contador_mod_n #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    logic [W-1:0] r_count;

    assign count = r_count;
    assign wrap  = (r_count == W'(N - 1));

    // The next value is exported so callers can register decodes aligned with count.
    always_comb begin
        count_next = r_count;
        if (reset) begin
            count_next = '0;
        end else if (en) begin
            count_next = wrap ? '0 : r_count + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        r_count <= count_next;
    end

endmodule

`default_nettype wire

// File: rtl/sincronizador_vga.sv
//------------------------------------------------------------------------------
// sincronizador_vga
// VGA timing generator: pixel enable, hsync/vsync, coordinates and video_on.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sincronizador_vga
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic               frame_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_STOP  = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_STOP  = VS_START + V_SYNC - 1;
    localparam int DIV_W    = $clog2(CLK_DIV);

    logic [DIV_W-1:0]   w_div;
    logic [DIV_W-1:0]   w_div_next_unused;
    logic               w_div_wrap;
    logic [COORD_W-1:0] w_h;
    logic [COORD_W-1:0] w_h_next;
    logic               w_h_wrap;
    logic [COORD_W-1:0] w_v;
    logic [COORD_W-1:0] w_v_next;
    logic               w_v_wrap;
    logic               w_line_end;
    logic               r_hsync;
    logic               r_vsync;

    contador_mod_n #(.N(CLK_DIV), .W(DIV_W)) u_div (
        .clk        (clk),
        .reset      (reset),
        .en         (1'b1),
        .count      (w_div),
        .count_next (w_div_next_unused),
        .wrap       (w_div_wrap)
    );

    contador_mod_n #(.N(H_TOTAL), .W(COORD_W)) u_h_cnt (
        .clk        (clk),
        .reset      (reset),
        .en         (w_div_wrap),
        .count      (w_h),
        .count_next (w_h_next),
        .wrap       (w_h_wrap)
    );

    assign w_line_end = w_div_wrap && w_h_wrap;

    contador_mod_n #(.N(V_TOTAL), .W(COORD_W)) u_v_cnt (
        .clk        (clk),
        .reset      (reset),
        .en         (w_line_end),
        .count      (w_v),
        .count_next (w_v_next),
        .wrap       (w_v_wrap)
    );

    // Sync flops decode the next counter value so they line up with pixel_x/pixel_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
        end else begin
            r_hsync <= in_window(w_h_next, COORD_W'(HS_START), COORD_W'(HS_STOP))
                       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync <= in_window(w_v_next, COORD_W'(VS_START), COORD_W'(VS_STOP))
                       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign p_tick     = w_div_wrap;
    assign frame_tick = w_line_end && w_v_wrap;
    assign pixel_x    = w_h;
    assign pixel_y    = w_v;
    assign video_on   = (w_h < COORD_W'(H_DISPLAY)) && (w_v < COORD_W'(V_DISPLAY));

endmodule

`default_nettype wire

// File: tb/tb_sincronizador_vga.sv
//------------------------------------------------------------------------------
// tb_sincronizador_vga
// Randomized-reset bench with an arithmetic timing model and literal checks.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sincronizador_vga;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       f_hs, f_vs, f_vid, f_pt, f_ft;
    logic [9:0] f_x, f_y;
    logic       a_hs, a_vs, a_vid, a_pt, a_ft;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_vid, b_pt, b_ft;
    logic [9:0] b_x, b_y;

    sincronizador_vga dut_full (
        .clk(clk), .reset(reset), .hsync(f_hs), .vsync(f_vs), .video_on(f_vid),
        .p_tick(f_pt), .frame_tick(f_ft), .pixel_x(f_x), .pixel_y(f_y)
    );

    sincronizador_vga #(
        .CLK_DIV(4), .H_DISPLAY(20), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_a (
        .clk(clk), .reset(reset), .hsync(a_hs), .vsync(a_vs), .video_on(a_vid),
        .p_tick(a_pt), .frame_tick(a_ft), .pixel_x(a_x), .pixel_y(a_y)
    );

    sincronizador_vga #(
        .CLK_DIV(2), .H_DISPLAY(20), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_b (
        .clk(clk), .reset(reset), .hsync(b_hs), .vsync(b_vs), .video_on(b_vid),
        .p_tick(b_pt), .frame_tick(b_ft), .pixel_x(b_x), .pixel_y(b_y)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Expected outputs after k unreset clock edges: pure arithmetic on elapsed time.
    function automatic logic [31:0] model(input int k, input int d,
                                          input int hd, input int hf, input int hs, input int hb,
                                          input int vd, input int vf, input int vs, input int vb);
        int ht = hd + hf + hs + hb;
        int vt = vd + vf + vs + vb;
        int p  = k / d;
        int h  = p % ht;
        int v  = (p / ht) % vt;
        logic tick  = ((k % d) == d - 1);
        logic hsy   = !((h >= hd + hf) && (h < hd + hf + hs));
        logic vsy   = !((v >= vd + vf) && (v < vd + vf + vs));
        logic vid   = (h < hd) && (v < vd);
        logic frame = tick && (h == ht - 1) && (v == vt - 1);
        return {7'd0, hsy, vsy, vid, tick, frame, 10'(h), 10'(v)};
    endfunction

    int   k = 0;
    logic started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            k       <= 0;
            started <= 1'b1;
        end else begin
            k <= k + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_full", {7'd0, f_hs, f_vs, f_vid, f_pt, f_ft, f_x, f_y},
                  model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33));
            check("model_a", {7'd0, a_hs, a_vs, a_vid, a_pt, a_ft, a_x, a_y},
                  model(k, 4, 20, 2, 4, 3, 10, 2, 2, 3));
            check("model_b", {7'd0, b_hs, b_vs, b_vid, b_pt, b_ft, b_x, b_y},
                  model(k, 2, 20, 2, 4, 3, 10, 2, 2, 3));
        end
    end

    initial begin
        int hs_low, hs_first_x, vs_low, vid_high, ft_a, ft_b, last_b, found;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_hsync", 32'(f_hs), 32'd1);
        check("rst_vsync", 32'(f_vs), 32'd1);
        check("rst_video_on", 32'(f_vid), 32'd1);
        check("rst_p_tick", 32'(f_pt), 32'd0);
        check("rst_xy", {12'd0, f_x, f_y}, 32'd0);
        reset = 1'b0;

        hs_low = 0; hs_first_x = -1; vs_low = 0; vid_high = 0; ft_a = 0; ft_b = 0; last_b = -1;
        for (int c = 1; c <= 3600; c++) begin
            @(negedge clk);
            if (c == 3) begin
                check("first_p_tick", 32'(f_pt), 32'd1);
                check("first_x_held", 32'(f_x), 32'd0);
            end
            if (c == 4) check("x_step", 32'(f_x), 32'd1);
            if (c <= 3200 && !f_hs) begin
                if (hs_first_x < 0) hs_first_x = int'(f_x);
                hs_low++;
            end
            if (c == 2560) check("video_off_640_0", 32'(f_vid), 32'd0);
            if (c == 3199) check("line_end_xy", {12'd0, f_x, f_y}, {12'd0, 10'd799, 10'd0});
            if (c == 3200) check("line_wrap_xy", {12'd0, f_x, f_y}, {12'd0, 10'd0, 10'd1});
            if (c == 1160) check("video_off_0_vd", 32'(a_vid), 32'd0);
            if (c <= 1972) begin
                if (!a_vs) vs_low++;
                if (a_vid) vid_high++;
                if (a_ft) begin
                    ft_a++;
                    check("frame_tick_xy", {12'd0, a_x, a_y}, {12'd0, 10'd28, 10'd16});
                end
            end
            if (c == 1972) check("frame_wrap_xy", {12'd0, a_x, a_y}, 32'd0);
            if (b_ft) begin
                if (last_b >= 0) check("frame_period_div2", 32'(c - last_b), 32'd986);
                last_b = c;
                ft_b++;
            end
        end
        check("hsync_low_clks", 32'(hs_low), 32'd384);
        check("hsync_start_x", 32'(hs_first_x), 32'd656);
        check("vsync_low_clks", 32'(vs_low), 32'd232);
        check("video_on_clks", 32'(vid_high), 32'd800);
        check("frame_ticks_a", 32'(ft_a), 32'd1);
        check("frame_ticks_b", 32'(ft_b), 32'd3);

        // One-clock reset while dut_a sits inside both sync pulses.
        found = 0;
        for (int c = 0; c < 4000 && found == 0; c++) begin
            @(negedge clk);
            if (a_y == 10'd13 && !a_hs) found = 1;
        end
        check("wait_sync_window", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_xy", {12'd0, a_x, a_y}, 32'd0);
        check("midreset_syncs", {30'd0, a_hs, a_vs}, 32'd3);
        check("midreset_p_tick", 32'(a_pt), 32'd0);

        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(50, 2500)) @(negedge clk);
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset = 1'b0;
        end
        repeat (2200) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
